mem_arbiter: RTL and testbench

- Memory arbiter sits directly downstream of the request unit.
- Takes its registered iRen/dRen/dWen strobes and addresses, and serialises them onto a single-ported RAM interface.
- Returns one-cycle iHit/dHit pulses with load data back to the request unit and datapath.
- Data accesses take priority over instruction fetch. RAM wait states, RAM errors and stalled accesses are handled by a small FSM with a wait counter.

---
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction/data requests onto a single-ported RAM.
// Data accesses beat instruction fetch; write beats read.
// Ports: CLK/nRST (async active-low reset); iRen/dRen/dWen request strobes with
// iaddr/daddr/dstore; iHit/dHit one-cycle completion pulses with iload/dload;
// ramREN/ramWEN/ramaddr/ramstore RAM drive, ramload/ramstate RAM response;
// err sticky error flag (RAM ERROR or wait timeout).
// Optional MEM_ARB_STATS_EN adds icount/dcount 32-bit hit counters.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iRen,
  input  logic              dRen,
  input  logic              dWen,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iHit,
  output logic              dHit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount
`endif
);
  typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam logic [7:0] MAX_W  = 8'(MAX_WAIT);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       acc, own, done, fault, hold;
  // own: the request that started the current access is still asserted;
  // dropping it aborts the access without a hit or error.
  always_comb begin
    acc     = state_q != IDLE;
    own     = (state_q == IREAD && iRen) || (state_q == DREAD && dRen) || (state_q == DWRITE && dWen);
    done    = own && ramstate == ACCESS;
    fault   = own && (ramstate == ERROR || (!ramstate[1] && cnt_q == MAX_W));
    hold    = own && !ramstate[1] && cnt_q != MAX_W;
    state_d = !acc ? (dWen ? DWRITE : dRen ? DREAD : iRen ? IREAD : IDLE) : hold ? state_q : IDLE;
    cnt_d   = hold ? cnt_q + 8'd1 : 8'd0;
    err_d   = err_q | fault;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign iHit     = done && state_q == IREAD;
  assign dHit     = done && state_q != IREAD;
  assign iload    = iHit ? ramload : '0;
  assign dload    = dHit && state_q == DREAD ? ramload : '0;
  assign ramREN   = state_q == IREAD || state_q == DREAD;
  assign ramWEN   = state_q == DWRITE;
  assign ramaddr  = state_q == IREAD ? iaddr : acc ? daddr : '0;
  assign ramstore = state_q == DWRITE ? dstore : '0;
  assign err      = err_q;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount_q, dcount_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= 32'd0;
      dcount_q <= 32'd0;
    end else begin
      icount_q <= icount_q + 32'(iHit);
      dcount_q <= dcount_q + 32'(dHit);
    end
  end
  assign icount = icount_q;
  assign dcount = dcount_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
module tb_mem_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        iRen = 1'b0, dRen = 1'b0, dWen = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        iHit, dHit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount, dcount;
`endif
  typedef struct packed {logic is_d; logic rd; logic [31:0] data;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, exp_i = 0, exp_d = 0;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iRen(iRen), .dRen(dRen), .dWen(dWen),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iHit(iHit), .dHit(dHit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
`ifdef MEM_ARB_STATS_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Hits are taken off the scoreboard mid-cycle; a hit with nothing expected is an error.
  always @(negedge CLK) begin
    if (iHit || dHit) begin
      if (q.size() == 0) check("unexpected_hit", 64'({iHit, dHit}), 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("hit_kind", 64'({iHit, dHit}), e.is_d ? 64'd1 : 64'd2);
        if (e.rd) check(e.is_d ? "dload" : "iload", 64'(e.is_d ? dload : iload), 64'(e.data));
      end
    end
  end

  // req = {iRen, dRen, dWen}; RAM reports BUSY for `busy` cycles then ACCESS.
  task automatic xfer(input logic [2:0] req, input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] data, input int busy);
    exp_t e;
    logic [31:0] ea;
    e.is_d = req[1] | req[0];
    e.rd   = !req[0];
    e.data = data;
    ea     = e.is_d ? da : ia;
    {iRen, dRen, dWen} = req;
    iaddr = ia; daddr = da; dstore = data; ramload = data; ramstate = FREE;
    q.push_back(e);
    if (e.is_d) exp_d++; else exp_i++;
    tick;
    ramstate = BUSY;
    for (int k = 0; k <= busy; k++) begin
      if (k == busy) ramstate = ACCESS;
      check("ram_en", 64'({ramREN, ramWEN}), req[0] ? 64'd1 : 64'd2);
      check("ramaddr", 64'(ramaddr), 64'(ea));
      check("ramstore", 64'(ramstore), req[0] ? 64'(data) : 64'd0);
      tick;
    end
    {iRen, dRen, dWen} = 3'b000;
    ramstate = FREE;
    check("hit_taken", 64'(q.size()), 64'd0);
    check("idle_en", 64'({ramREN, ramWEN}), 64'd0);
  endtask

  task automatic do_reset;
    nRST = 1'b0;
    {iRen, dRen, dWen} = 3'b000;
    ramstate = FREE;
    tick;
    check("rst_ctl", 64'({ramREN, ramWEN, iHit, dHit, err}), 64'd0);
    check("rst_ram", {ramaddr, ramstore}, 64'd0);
    check("rst_load", {iload, dload}, 64'd0);
    tick;
    nRST = 1'b1;
    exp_i = 0;
    exp_d = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_async", 64'({ramREN, ramWEN, iHit, dHit, err}), 64'd0);
    tick;
    do_reset;
    tick;
    check("post_rst", 64'({ramREN, ramWEN, err}), 64'd0);
    // single fetch, then data priority over fetch, then a write with wait states
    xfer(3'b100, 32'h40, 32'h0, 32'hDEADBEEF, 0);
    xfer(3'b110, 32'h80, 32'h100, 32'hCAFE0001, 0);
    xfer(3'b100, 32'h80, 32'h100, 32'hCAFE0002, 0);
    xfer(3'b001, 32'h0, 32'h200, 32'h00001234, 3);
    xfer(3'b011, 32'h0, 32'h300, 32'h000055AA, 1);
    xfer(3'b010, 32'h0, 32'h44, 32'h00000077, 2);
    // timeout: 15 waiting cycles allowed, giving up on the 16th
    dRen = 1'b1; daddr = 32'h500; ramstate = BUSY;
    tick;
    for (int k = 1; k < 16; k++) tick;
    check("to_last_wait", 64'({ramREN, err}), 64'd2);
    tick;
    check("to_idle_err", 64'({ramREN, err}), 64'd1);
    dRen = 1'b0; ramstate = FREE;
    xfer(3'b100, 32'h10, 32'h0, 32'h00000001, 0);
    check("err_sticky", 64'(err), 64'd1);
    do_reset;
    check("err_cleared", 64'(err), 64'd0);
    // RAM error during a fetch
    iRen = 1'b1; iaddr = 32'h20; ramload = 32'hBAD; ramstate = FREE;
    tick;
    ramstate = ERROR;
    check("errcase_ren", 64'({ramREN, err}), 64'd2);
    tick;
    check("errcase_idle", 64'({ramREN, err}), 64'd1);
    iRen = 1'b0; ramstate = FREE;
    tick;
    // reset in the middle of a write with RAM ready in the same instant
    dWen = 1'b1; daddr = 32'h400; dstore = 32'h9; ramstate = BUSY;
    tick;
    check("mid_wen", 64'(ramWEN), 64'd1);
    tick;
    nRST = 1'b0; ramstate = ACCESS;
    #1;
    check("mid_rst_ctl", 64'({ramWEN, ramREN, dHit}), 64'd0);
    check("mid_rst_ram", {ramaddr, ramstore}, 64'd0);
    dWen = 1'b0; ramstate = FREE;
    tick;
    nRST = 1'b1;
    exp_i = 0; exp_d = 0;
    tick;
    check("mid_rst_err", 64'(err), 64'd0);
    // hit counting run: 3 fetches, 2 data accesses, then an aborted read
    xfer(3'b100, 32'h1000, 32'h0, 32'h11, 0);
    xfer(3'b100, 32'h1004, 32'h0, 32'h22, 1);
    xfer(3'b100, 32'h1008, 32'h0, 32'h33, 0);
    xfer(3'b010, 32'h0, 32'h2000, 32'h44, 0);
    xfer(3'b001, 32'h0, 32'h2004, 32'h55, 2);
    dRen = 1'b1; daddr = 32'h60; ramstate = BUSY;
    tick;
    check("abort_ren", 64'(ramREN), 64'd1);
    tick;
    dRen = 1'b0;
    check("abort_cycle_ren", 64'(ramREN), 64'd1);
    tick;
    check("abort_idle", 64'({ramREN, err}), 64'd0);
    ramstate = FREE;
    tick;
`ifdef MEM_ARB_STATS_EN
    check("icount", 64'(icount), 64'(exp_i));
    check("dcount", 64'(dcount), 64'(exp_d));
`endif
    check("pending_end", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
